calc_seq: RTL and testbench

CALC_SEQ -- requirements
Module: calc_seq

---
 rtl/calc_seq.sv | 187 ++++++++++++++++++
 tb/tb_calc_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_seq.sv
// rtl/calc_seq.sv - button-driven calculator sequencer with debounced inputs
module calc_seq #(
    parameter int DB_CYCLES = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] dip_sw,
    input  logic [3:0] btn,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [1:0] alu_op,
    output logic       alu_start,
    input  logic       alu_done,
    input  logic [7:0] alu_result,
    input  logic       alu_err,
    output logic [7:0] leds,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_GOT_A, S_GOT_B, S_WAIT, S_DONE, S_ERR
    } state_t;

    logic [3:0]      sync1_q, sync2_q;
    logic [3:0]      db_q, db_d, dbp_q;
    logic [3:0][7:0] db_cnt_q, db_cnt_d;

    state_t      state_q, state_d;
    logic [7:0]  a_q, a_d, b_q, b_d, leds_q, leds_d;
    logic [1:0]  op_q, op_d;
    logic        start_q, start_d, busy_q, busy_d;
    logic [15:0] wcnt_q, wcnt_d;

    logic [3:0] press;
    logic       ev_clr, ev_exe, ev_b, ev_a;

    // Each bit's counter tracks how long the synchronized level has disagreed.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == 8'(DB_CYCLES - 1)) begin
                    db_d[i]     = sync2_q[i];
                    db_cnt_d[i] = 8'd0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 8'd1;
                end
            end else begin
                db_cnt_d[i] = 8'd0;
            end
        end
    end

    assign press  = db_q & ~dbp_q;
    assign ev_clr = press[3];
    assign ev_exe = press[2] & ~press[3];
    assign ev_b   = press[1] & ~(|press[3:2]);
    assign ev_a   = press[0] & ~(|press[3:1]);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        leds_d  = leds_q;
        start_d = 1'b0;
        wcnt_d  = wcnt_q;
        if (ev_clr) begin
            state_d = S_IDLE;
            a_d     = 8'h00;
            b_d     = 8'h00;
            op_d    = 2'd0;
            leds_d  = 8'h00;
            wcnt_d  = 16'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ev_a) begin
                        a_d     = dip_sw;
                        leds_d  = dip_sw;
                        state_d = S_GOT_A;
                    end
                end
                S_GOT_A: begin
                    if (ev_a) begin
                        a_d    = dip_sw;
                        leds_d = dip_sw;
                    end else if (ev_b) begin
                        b_d     = dip_sw;
                        leds_d  = dip_sw;
                        state_d = S_GOT_B;
                    end
                end
                S_GOT_B: begin
                    if (ev_a) begin
                        a_d     = dip_sw;
                        state_d = S_GOT_A;
                    end else if (ev_b) begin
                        b_d    = dip_sw;
                        leds_d = dip_sw;
                    end else if (ev_exe) begin
                        op_d    = dip_sw[1:0];
                        start_d = 1'b1;
                        wcnt_d  = 16'd0;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    wcnt_d = wcnt_q + 16'd1;
                    if (alu_done) begin
                        if (alu_err) begin
                            leds_d  = 8'hFF;
                            state_d = S_ERR;
                        end else begin
                            // Result becomes the next operand A so operations chain.
                            leds_d  = alu_result;
                            a_d     = alu_result;
                            state_d = S_DONE;
                        end
                    end else if (wcnt_q + 16'd1 == 16'(TIMEOUT)) begin
                        leds_d  = 8'hFF;
                        state_d = S_ERR;
                    end
                end
                S_DONE: begin
                    if (ev_b) begin
                        b_d     = dip_sw;
                        leds_d  = dip_sw;
                        state_d = S_GOT_B;
                    end else if (ev_a) begin
                        a_d     = dip_sw;
                        state_d = S_GOT_A;
                    end
                end
                S_ERR: begin
                    leds_d = 8'hFF;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        busy_d = (state_d == S_WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 4'd0;
            sync2_q  <= 4'd0;
            db_q     <= 4'd0;
            dbp_q    <= 4'd0;
            db_cnt_q <= '0;
            state_q  <= S_IDLE;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            op_q     <= 2'd0;
            leds_q   <= 8'h00;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            wcnt_q   <= 16'd0;
        end else begin
            sync1_q  <= btn;
            sync2_q  <= sync1_q;
            db_q     <= db_d;
            dbp_q    <= db_q;
            db_cnt_q <= db_cnt_d;
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            leds_q   <= leds_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            wcnt_q   <= wcnt_d;
        end
    end

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_op    = op_q;
    assign alu_start = start_q;
    assign leds      = leds_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_calc_seq.sv
// tb/tb_calc_seq.sv - self-checking bench for calc_seq against a behavioural model
module tb_calc_seq;

    localparam int DB  = 4;
    localparam int TMO = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] dip_sw = 8'h00;
    logic [3:0] btn = 4'h0;
    logic [7:0] alu_a, alu_b, leds;
    logic [1:0] alu_op;
    logic       alu_start, busy;
    logic       alu_done = 1'b0;
    logic [7:0] alu_result = 8'h00;
    logic       alu_err = 1'b0;

    calc_seq #(.DB_CYCLES(DB), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .dip_sw(dip_sw), .btn(btn),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
        .alu_done(alu_done), .alu_result(alu_result), .alu_err(alu_err),
        .leds(leds), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int starts = 0;
    int busy_cycles = 0;
    bit chk_en = 1'b0;
    logic start_prev = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Datapath stand-in: answers three cycles after a start pulse.
    bit         resp_on = 1'b1;
    bit         resp_err = 1'b0;
    int         resp_cnt = 0;
    logic [7:0] resp_val = 8'h00;

    always @(negedge clk) begin
        alu_done = 1'b0;
        alu_err  = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                alu_done   = 1'b1;
                alu_err    = resp_err;
                alu_result = resp_val;
            end
        end
        if (alu_start && resp_on) begin
            resp_cnt = 3;
            case (alu_op)
                2'd0:    resp_val = alu_a + alu_b;
                2'd1:    resp_val = alu_a - alu_b;
                default: resp_val = alu_a;
            endcase
        end
    end

    // Behavioural model: button history -> accepted presses -> calculator registers.
    typedef enum {M_IDLE, M_GOT_A, M_GOT_B, M_WAIT, M_DONE, M_ERR} mst_t;
    mst_t       m_st = M_IDLE;
    logic [3:0] m_seen1 = 0, m_seen2 = 0, m_lvl = 0, m_prev = 0;
    int         m_run [4] = '{0, 0, 0, 0};
    logic [7:0] m_a = 0, m_b = 0, m_leds = 0;
    logic [1:0] m_op = 0;
    logic       m_start = 0, m_busy = 0;
    int         m_wait = 0;
    int         ev;
    logic [3:0] rise;

    always @(posedge clk) begin
        if (rst) begin
            m_st = M_IDLE; m_a = 0; m_b = 0; m_op = 0; m_leds = 0;
            m_start = 0; m_busy = 0; m_wait = 0;
            m_seen1 = 0; m_seen2 = 0; m_lvl = 0; m_prev = 0;
            for (int k = 0; k < 4; k++) m_run[k] = 0;
        end else begin
            rise = m_lvl & ~m_prev;
            ev = -1;
            for (int k = 3; k >= 0; k--) if (rise[k] && ev < 0) ev = k;
            m_start = 0;
            if (ev == 3) begin
                m_st = M_IDLE; m_a = 0; m_b = 0; m_op = 0; m_leds = 0;
            end else begin
                case (m_st)
                    M_IDLE:  if (ev == 0) begin m_a = dip_sw; m_leds = dip_sw; m_st = M_GOT_A; end
                    M_GOT_A: if (ev == 0) begin m_a = dip_sw; m_leds = dip_sw; end
                             else if (ev == 1) begin m_b = dip_sw; m_leds = dip_sw; m_st = M_GOT_B; end
                    M_GOT_B: if (ev == 0) begin m_a = dip_sw; m_st = M_GOT_A; end
                             else if (ev == 1) begin m_b = dip_sw; m_leds = dip_sw; end
                             else if (ev == 2) begin m_op = dip_sw[1:0]; m_start = 1; m_wait = 0; m_st = M_WAIT; end
                    M_WAIT: begin
                        m_wait++;
                        if (alu_done && alu_err) begin m_leds = 8'hFF; m_st = M_ERR; end
                        else if (alu_done) begin m_leds = alu_result; m_a = alu_result; m_st = M_DONE; end
                        else if (m_wait == TMO) begin m_leds = 8'hFF; m_st = M_ERR; end
                    end
                    M_DONE:  if (ev == 1) begin m_b = dip_sw; m_leds = dip_sw; m_st = M_GOT_B; end
                             else if (ev == 0) begin m_a = dip_sw; m_st = M_GOT_A; end
                    default: m_leds = 8'hFF;
                endcase
            end
            m_busy = (m_st == M_WAIT);
            m_prev = m_lvl;
            for (int k = 0; k < 4; k++) begin
                if (m_seen2[k] != m_lvl[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DB) begin m_lvl[k] = m_seen2[k]; m_run[k] = 0; end
                end else begin
                    m_run[k] = 0;
                end
            end
            m_seen2 = m_seen1;
            m_seen1 = btn;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_leds",   16'(leds),   16'(m_leds));
            chk("model_alu_a",  16'(alu_a),  16'(m_a));
            chk("model_alu_b",  16'(alu_b),  16'(m_b));
            chk("model_alu_op", 16'(alu_op), 16'(m_op));
            chk("model_start",  16'(alu_start), 16'(m_start));
            chk("model_busy",   16'(busy),   16'(m_busy));
            chk("no_double_start", 16'(alu_start & start_prev), 16'd0);
            start_prev = alu_start;
            if (alu_start) starts++;
            if (busy) busy_cycles++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_down(input int b, input logic [7:0] d);
        dip_sw = d;
        btn[b] = 1'b1;
        idle(8);
    endtask

    task automatic release_btn(input int b);
        btn[b] = 1'b0;
        idle(12);
    endtask

    task automatic press(input int b, input logic [7:0] d);
        press_down(b, d);
        release_btn(b);
    endtask

    int bounce_len [6] = '{3, 2, 2, 1, 3, 3};

    initial begin
        idle(3);
        rst = 1'b0;
        chk_en = 1'b1;
        idle(1);
        chk("reset_leds",  16'(leds), 16'h00);
        chk("reset_start", 16'(alu_start), 16'd0);
        chk("reset_busy",  16'(busy), 16'd0);
        chk("reset_alu_a", 16'(alu_a), 16'h00);
        chk("reset_alu_b", 16'(alu_b), 16'h00);

        press(0, 8'h21);
        press(1, 8'h05);
        press_down(2, 8'h00);
        chk("add_alu_a",  16'(alu_a), 16'h21);
        chk("add_alu_b",  16'(alu_b), 16'h05);
        chk("add_alu_op", 16'(alu_op), 16'd0);
        chk("add_busy",   16'(busy), 16'd1);
        release_btn(2);
        chk("add_leds",   16'(leds), 16'h26);
        chk("add_starts", 16'(starts), 16'd1);
        chk("add_busy_off", 16'(busy), 16'd0);

        press(1, 8'h02);
        press_down(2, 8'h01);
        chk("chain_alu_a",  16'(alu_a), 16'h26);
        chk("chain_alu_b",  16'(alu_b), 16'h02);
        chk("chain_alu_op", 16'(alu_op), 16'd1);
        release_btn(2);
        chk("chain_leds", 16'(leds), 16'h24);

        press(3, 8'h00);
        dip_sw = 8'h5A;
        for (int i = 0; i < 6; i++) begin
            btn[0] = (i % 2 == 0);
            idle(bounce_len[i]);
        end
        idle(8);
        chk("bounce_no_capture", 16'(leds), 16'h00);
        btn[0] = 1'b1;
        idle(10);
        release_btn(0);
        chk("bounce_capture", 16'(leds), 16'h5A);
        chk("bounce_alu_a",   16'(alu_a), 16'h5A);

        press(1, 8'h11);
        dip_sw = 8'h03;
        btn = 4'b1100;
        idle(8);
        btn = 4'b0000;
        idle(12);
        chk("clr_exe_starts", 16'(starts), 16'd2);
        chk("clr_exe_leds",   16'(leds), 16'h00);
        chk("clr_exe_busy",   16'(busy), 16'd0);
        chk("clr_exe_alu_b",  16'(alu_b), 16'h00);

        resp_err = 1'b1;
        press(0, 8'h10);
        press(1, 8'h00);
        press(2, 8'h03);
        chk("err_leds", 16'(leds), 16'hFF);
        press(0, 8'h77);
        chk("err_hold_leds", 16'(leds), 16'hFF);
        press(3, 8'h00);
        chk("err_clear_leds", 16'(leds), 16'h00);
        chk("err_clear_busy", 16'(busy), 16'd0);
        resp_err = 1'b0;

        resp_on = 1'b0;
        press(0, 8'h01);
        press(1, 8'h02);
        busy_cycles = 0;
        press(2, 8'h00);
        idle(15);
        chk("timeout_leds", 16'(leds), 16'hFF);
        chk("timeout_busy_cycles", 16'(busy_cycles), 16'd20);
        press(3, 8'h00);

        press(0, 8'h33);
        press(1, 8'h44);
        press_down(2, 8'h00);
        idle(2);
        chk("pre_rst_busy", 16'(busy), 16'd1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("rst_busy",  16'(busy), 16'd0);
        chk("rst_leds",  16'(leds), 16'h00);
        chk("rst_alu_a", 16'(alu_a), 16'h00);
        chk("rst_alu_b", 16'(alu_b), 16'h00);
        release_btn(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
        $fatal(1);
    end

endmodule
